// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared types, defaults and helpers for the poly tone generator
package tone_pkg;

    localparam int CNT_W_DEF = 26;
    localparam int CH_W_MAX  = 8;

    // Note command as it arrives from the key decoder
    typedef struct packed {
        logic [CH_W_MAX-1:0]  ch;
        logic [CNT_W_DEF-1:0] half_period;
        logic                 gate;
    } note_cmd_t;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // Number of set bits in a word of up to 32 channels
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tone_channel.sv
// rtl/tone_channel.sv - one square-wave channel with run/idle FSM and deferred retune slot
module tone_channel
    import tone_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic             cmd_on,
    input  logic [CNT_W-1:0] cmd_hp,
    output logic             tone,
    output logic             active,
    output logic             pending
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [CNT_W-1:0] pend_hp_q, pend_hp_d;
    logic             tone_q, tone_d;
    logic             pend_q, pend_d;
    logic             pend_on_q, pend_on_d;
    logic             wrap;
    logic             fall;

    // End of a half period; a falling edge is the only point where new settings may land
    assign wrap = (cnt_q == hp_q - CNT_W'(1));
    assign fall = (state_q == CH_RUN) && wrap && tone_q;

    // State, counter, tone and pending-slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CH_IDLE;
            cnt_q     <= '0;
            hp_q      <= '0;
            pend_hp_q <= '0;
            tone_q    <= 1'b0;
            pend_q    <= 1'b0;
            pend_on_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hp_q      <= hp_d;
            pend_hp_q <= pend_hp_d;
            tone_q    <= tone_d;
            pend_q    <= pend_d;
            pend_on_q <= pend_on_d;
        end
    end

    // Next state: idle channels start at once, running channels defer commands to the falling edge
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hp_d      = hp_q;
        tone_d    = tone_q;
        pend_d    = pend_q;
        pend_hp_d = pend_hp_q;
        pend_on_d = pend_on_q;
        if (state_q == CH_IDLE) begin
            if (cmd_valid && cmd_on) begin
                state_d = CH_RUN;
                hp_d    = cmd_hp;
                cnt_d   = '0;
                tone_d  = 1'b0;
            end
        end else begin
            if (wrap) begin
                cnt_d  = '0;
                tone_d = !tone_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (fall && pend_q) begin
                pend_d = 1'b0;
                cnt_d  = '0;
                tone_d = 1'b0;
                if (pend_on_q) begin
                    hp_d = pend_hp_q;
                end else begin
                    state_d = CH_IDLE;
                end
            end
            // Only reachable with the slot empty, so a same-cycle falling edge leaves it waiting
            if (cmd_valid) begin
                pend_d    = 1'b1;
                pend_hp_d = cmd_hp;
                pend_on_d = cmd_on;
            end
        end
    end

    assign tone    = tone_q;
    assign active  = (state_q == CH_RUN);
    assign pending = pend_q;

endmodule

// File: rtl/poly_tone_gen.sv
// rtl/poly_tone_gen.sv - multi-channel square-wave tone generator; POLY_TONE_GEN_OCTAVE_SHIFT_EN adds octave_down
module poly_tone_gen
    import tone_pkg::*;
#(
    parameter  int CNT_W  = CNT_W_DEF,
    parameter  int NUM_CH = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int MIX_W  = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              note_valid,
    output logic              note_ready,
    input  logic [CH_W-1:0]   note_ch,
    input  logic [CNT_W-1:0]  note_half_period,
    input  logic              note_gate,
`ifdef POLY_TONE_GEN_OCTAVE_SHIFT_EN
    input  logic [1:0]        octave_down,
`endif
    output logic [NUM_CH-1:0] tone_out,
    output logic [NUM_CH-1:0] active_mask,
    output logic [MIX_W-1:0]  mix_level
);

    logic [CNT_W-1:0]  hp_eff;
    logic              cmd_on;
    logic              xfer;
    logic [NUM_CH-1:0] pending;

`ifdef POLY_TONE_GEN_OCTAVE_SHIFT_EN
    logic [CNT_W+2:0] hp_wide;

    // Shift down by octaves lengthens the half period; clamp rather than wrap
    assign hp_wide = {3'b000, note_half_period} << octave_down;
    assign hp_eff  = (|hp_wide[CNT_W+2:CNT_W]) ? {CNT_W{1'b1}} : hp_wide[CNT_W-1:0];
`else
    assign hp_eff = note_half_period;
`endif

    assign cmd_on = note_gate && (hp_eff != '0);
    assign xfer   = note_valid && note_ready;

    // Ready follows the target channel's pending slot; channels beyond NUM_CH swallow commands
    always_comb begin
        note_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(note_ch) == i) begin
                note_ready = !pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tone_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .cmd_valid (xfer && (32'(note_ch) == g)),
            .cmd_on    (cmd_on),
            .cmd_hp    (hp_eff),
            .tone      (tone_out[g]),
            .active    (active_mask[g]),
            .pending   (pending[g])
        );
    end

    // Registered count of high channels for the mixer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_level <= '0;
        end else begin
            mix_level <= MIX_W'(popcount(32'(tone_out)));
        end
    end

endmodule

// File: tb/tb_poly_tone_gen.sv
// tb/tb_poly_tone_gen.sv - directed vector bench for poly_tone_gen
module tb_poly_tone_gen;

    logic        clk;
    logic        rst_n;
    logic        note_valid;
    logic        note_ready;
    logic [1:0]  note_ch;
    logic [25:0] note_half_period;
    logic        note_gate;
    logic [3:0]  tone_out;
    logic [3:0]  active_mask;
    logic [2:0]  mix_level;
`ifdef POLY_TONE_GEN_OCTAVE_SHIFT_EN
    logic [1:0]  octave_down;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int v, ch, hp, g, rdy, tone, act, mix;
    } vec_t;

    vec_t       vecs[16];
    logic [3:0] hist[60];
    logic [3:0] prev;
    logic [0:5] pat;
    int         hps[3];
    int         maxmix;
    int         last_rise;
    int         rises;
    int         ones;

    poly_tone_gen #(
        .CNT_W  (26),
        .NUM_CH (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .note_valid       (note_valid),
        .note_ready       (note_ready),
        .note_ch          (note_ch),
        .note_half_period (note_half_period),
        .note_gate        (note_gate),
`ifdef POLY_TONE_GEN_OCTAVE_SHIFT_EN
        .octave_down      (octave_down),
`endif
        .tone_out         (tone_out),
        .active_mask      (active_mask),
        .mix_level        (mix_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input int ch, input int hp, input int g);
        note_valid       = (v != 0);
        note_ch          = 2'(ch);
        note_half_period = 26'(hp);
        note_gate        = (g != 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    function automatic vec_t row(int v, int ch, int hp, int g, int tone, int act, int mix);
        vec_t r;
        r.v = v; r.ch = ch; r.hp = hp; r.g = g; r.rdy = 1;
        r.tone = tone; r.act = act; r.mix = mix;
        return r;
    endfunction

    initial begin
`ifdef POLY_TONE_GEN_OCTAVE_SHIFT_EN
        octave_down = 2'd0;
`endif
        rst_n = 1'b0;
        drive(0, 0, 0, 0);

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 50), $urandom_range(0, 1));
            tick();
        end
        #1;
        chk("rst_tone", 32'(tone_out), 0);
        chk("rst_active", 32'(active_mask), 0);
        chk("rst_mix", 32'(mix_level), 0);
        chk("rst_ready", 32'(note_ready), 1);
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rel_tone", 32'(tone_out), 0);
        chk("rel_active", 32'(active_mask), 0);
        chk("rel_mix", 32'(mix_level), 0);

        // ch0 hp=3 from idle, then ch3 hp=1 joins
        vecs[0]  = row(1, 0, 3, 1, 4'b0000, 4'b0001, 0);
        vecs[1]  = row(0, 0, 0, 0, 4'b0000, 4'b0001, 0);
        vecs[2]  = row(0, 0, 0, 0, 4'b0000, 4'b0001, 0);
        vecs[3]  = row(0, 0, 0, 0, 4'b0001, 4'b0001, 0);
        vecs[4]  = row(0, 0, 0, 0, 4'b0001, 4'b0001, 1);
        vecs[5]  = row(0, 0, 0, 0, 4'b0001, 4'b0001, 1);
        vecs[6]  = row(0, 0, 0, 0, 4'b0000, 4'b0001, 1);
        vecs[7]  = row(0, 0, 0, 0, 4'b0000, 4'b0001, 0);
        vecs[8]  = row(0, 0, 0, 0, 4'b0000, 4'b0001, 0);
        vecs[9]  = row(0, 0, 0, 0, 4'b0001, 4'b0001, 0);
        vecs[10] = row(1, 3, 1, 1, 4'b0001, 4'b1001, 1);
        vecs[11] = row(0, 0, 0, 0, 4'b1001, 4'b1001, 1);
        vecs[12] = row(0, 0, 0, 0, 4'b0000, 4'b1001, 2);
        vecs[13] = row(0, 0, 0, 0, 4'b1000, 4'b1001, 0);
        vecs[14] = row(0, 0, 0, 0, 4'b0000, 4'b1001, 1);
        vecs[15] = row(0, 0, 0, 0, 4'b1001, 4'b1001, 0);
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v, vecs[i].ch, vecs[i].hp, vecs[i].g);
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(note_ready), vecs[i].rdy);
            tick();
            chk($sformatf("vec%0d_tone", i), 32'(tone_out), vecs[i].tone);
            chk($sformatf("vec%0d_active", i), 32'(active_mask), vecs[i].act);
            chk($sformatf("vec%0d_mix", i), 32'(mix_level), vecs[i].mix);
        end

        // Retune ch1 from hp=4 to hp=2 mid high phase
        do_reset();
        tick();
        drive(1, 1, 4, 1);
        tick();
        drive(0, 1, 0, 0);
        chk("rt_start_active", 32'(active_mask[1]), 1);
        chk("rt_start_tone", 32'(tone_out[1]), 0);
        repeat (3) tick();
        chk("rt_low_end", 32'(tone_out[1]), 0);
        tick();
        chk("rt_high_start", 32'(tone_out[1]), 1);
        tick();
        drive(1, 1, 2, 1);
        #1;
        chk("rt_ready_accept", 32'(note_ready), 1);
        tick();
        drive(0, 1, 0, 0);
        #1;
        chk("rt_ready_pending", 32'(note_ready), 0);
        chk("rt_high_hold1", 32'(tone_out[1]), 1);
        tick();
        chk("rt_high_hold2", 32'(tone_out[1]), 1);
        chk("rt_ready_pending2", 32'(note_ready), 0);
        tick();
        chk("rt_fall", 32'(tone_out[1]), 0);
        chk("rt_ready_free", 32'(note_ready), 1);
        pat = 6'b011001;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rt_new%0d", k), 32'(tone_out[1]), int'(pat[k]));
        end

        // Key off: ch2 via gate=0, ch3 via hp=0, OFF to an idle channel
        do_reset();
        tick();
        drive(1, 2, 2, 1);
        tick();
        drive(1, 2, 5, 0);
        #1;
        chk("ko_ready_accept", 32'(note_ready), 1);
        tick();
        drive(0, 2, 0, 0);
        #1;
        chk("ko_ready_pending", 32'(note_ready), 0);
        tick();
        tick();
        chk("ko_active_before", 32'(active_mask[2]), 1);
        chk("ko_tone_before", 32'(tone_out[2]), 1);
        tick();
        chk("ko_active_after", 32'(active_mask[2]), 0);
        chk("ko_tone_after", 32'(tone_out[2]), 0);
        chk("ko_ready_after", 32'(note_ready), 1);
        repeat (3) tick();
        chk("ko_quiet_tone", 32'(tone_out), 0);
        chk("ko_quiet_active", 32'(active_mask), 0);
        drive(1, 3, 1, 1);
        tick();
        drive(1, 3, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        chk("ko_hp0_active_before", 32'(active_mask[3]), 1);
        chk("ko_hp0_tone_before", 32'(tone_out[3]), 1);
        tick();
        chk("ko_hp0_active_after", 32'(active_mask[3]), 0);
        chk("ko_hp0_tone_after", 32'(tone_out[3]), 0);
        drive(1, 0, 7, 0);
        #1;
        chk("ko_idle_ready", 32'(note_ready), 1);
        tick();
        drive(0, 0, 0, 0);
        chk("ko_idle_active", 32'(active_mask), 0);
        tick();
        chk("ko_idle_tone", 32'(tone_out), 0);
        drive(1, 0, 2, 1);
        tick();
        drive(0, 0, 0, 0);
        chk("ko_idle_restart", 32'(active_mask), 4'b0001);

        // Multi-channel mix: ch0 hp=2, ch1 hp=3, ch2 hp=5
        do_reset();
        tick();
        drive(1, 0, 2, 1);
        tick();
        drive(1, 1, 3, 1);
        tick();
        drive(1, 2, 5, 1);
        tick();
        drive(0, 0, 0, 0);
        maxmix = 0;
        for (int n = 0; n < 60; n++) begin
            prev = tone_out;
            tick();
            hist[n] = tone_out;
            ones = 0;
            for (int b = 0; b < 4; b++) begin
                if (prev[b]) ones++;
            end
            chk($sformatf("mix_c%0d", n), 32'(mix_level), ones);
            if (int'(mix_level) > maxmix) maxmix = int'(mix_level);
        end
        chk("mix_max", maxmix, 3);
        hps[0] = 2;
        hps[1] = 3;
        hps[2] = 5;
        for (int c = 0; c < 3; c++) begin
            last_rise = -1;
            rises = 0;
            for (int n = 1; n < 60; n++) begin
                if (!hist[n-1][c] && hist[n][c]) begin
                    if (last_rise >= 0) chk($sformatf("mc_ch%0d_period", c), n - last_rise, 2 * hps[c]);
                    last_rise = n;
                    rises++;
                end
                if (hist[n-1][c] && !hist[n][c] && last_rise >= 0) begin
                    chk($sformatf("mc_ch%0d_high", c), n - last_rise, hps[c]);
                end
            end
            chk($sformatf("mc_ch%0d_rises", c), (rises >= 3) ? 1 : 0, 1);
        end

        // Async reset mid-run with a pending command on ch0
        drive(1, 0, 3, 1);
        tick();
        drive(0, 0, 0, 0);
        #1;
        chk("ar_pending", 32'(note_ready), 0);
        chk("ar_active_before", 32'(active_mask), 4'b0111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_tone", 32'(tone_out), 0);
        chk("ar_active", 32'(active_mask), 0);
        chk("ar_mix", 32'(mix_level), 0);
        chk("ar_ready", 32'(note_ready), 1);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("ar_quiet%0d", k), 32'({tone_out, active_mask}), 0);
        end

`ifdef POLY_TONE_GEN_OCTAVE_SHIFT_EN
        // Octave shift: 5<<2 = 20, and 2^25<<3 saturates
        do_reset();
        tick();
        octave_down = 2'd2;
        drive(1, 0, 5, 1);
        tick();
        octave_down = 2'd0;
        drive(0, 0, 0, 0);
        chk("oct_hp", 32'(dut.g_ch[0].u_ch.hp_q), 20);
        repeat (19) tick();
        chk("oct_low_end", 32'(tone_out[0]), 0);
        tick();
        chk("oct_high", 32'(tone_out[0]), 1);
        octave_down = 2'd3;
        drive(1, 1, 33554432, 1);
        tick();
        octave_down = 2'd0;
        drive(0, 0, 0, 0);
        chk("oct_sat", 32'(dut.g_ch[1].u_ch.hp_q), 26'h3FFFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
